// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores into a two-word register window
// feed a small byte FIFO that is serialized LSB-first on tx.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        wr_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] w_data,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
    logic [7:0]      fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            offset;
    logic            full;
    logic            push_req;
    logic            push_ok;
    logic            clr_req;
    logic            pop;
    logic            baud_done;
    logic            unused_bits;

    assign sel       = (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign offset    = mem_addr[2];
    assign full      = (count_q == DEPTH_N);
    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign tx        = tx_q;
    assign rd_data   = (sel && offset) ? {29'b0, overflow_q, full, busy} : 32'b0;
    assign push_req  = clk_en && wr_en && sel && !offset;
    assign clr_req   = clk_en && wr_en && sel && offset && w_data[2];
    // A full FIFO still accepts a byte on the edge where the FSM pops one.
    assign push_ok   = push_req && (!full || pop);
    assign baud_done = (baud_q == BAUD_LAST);
    assign unused_bits = ^{mem_addr[1:0], w_data[31:8]};

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem_q[rd_ptr_q];
                        baud_d  = '0;
                        tx_d    = 1'b0;
                        state_d = START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_d  = '0;
                        idx_d   = 3'd0;
                        tx_d    = shift_q[0];
                        state_d = DATA;
                    end else begin
                        baud_d = baud_q + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_d  = '0;
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            tx_d = shift_q[1];
                        end
                    end else begin
                        baud_d = baud_q + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_d  = '0;
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        baud_d = baud_q + CW'(1);
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = w_data[7:0];
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
        // Setting the sticky flag takes priority over a same-edge clear.
        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end else if (clr_req) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            fifo_mem_q <= '{default: 8'h00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a queue-based frame model checked every cycle, a
// tx-line decoder, directed scenarios with literal expectations, and random traffic.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'hFFFF0000;
    localparam logic [31:0] TXDATA = 32'hFFFF0000;
    localparam logic [31:0] STATUS = 32'hFFFF0004;

    logic        clk_100M = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        wr_en;
    logic [31:0] mem_addr;
    logic [31:0] w_data;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_on = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_100M(clk_100M),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .wr_en   (wr_en),
        .mem_addr(mem_addr),
        .w_data  (w_data),
        .sel     (sel),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic checkOutputBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    // Behavioural model: a byte queue plus "which cycle of which frame" bookkeeping.
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    bit         m_in_frame = 0;
    int         m_pos      = 0;
    logic [7:0] m_byte     = 8'h00;
    bit         m_ovf      = 0;
    bit         m_pop, m_hit, m_push, m_clr, m_set;

    always @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_in_frame = 0;
            m_pos      = 0;
            m_ovf      = 0;
        end else if (clk_en) begin
            m_hit  = ((mem_addr & 32'hFFFFFFF8) == BASE);
            m_push = wr_en && m_hit && !mem_addr[2];
            m_clr  = wr_en && m_hit && mem_addr[2] && w_data[2];
            m_set  = 0;
            m_pop  = !m_in_frame && (m_q.size() != 0);
            if (m_in_frame) begin
                if (m_pos == 10 * CPB - 1) m_in_frame = 0;
                else m_pos++;
            end
            if (m_pop) begin
                m_byte = m_q.pop_front();
                m_sent.push_back(m_byte);
                m_in_frame = 1;
                m_pos = 0;
            end
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(w_data[7:0]);
                else m_set = 1;
            end
            if (m_set) m_ovf = 1;
            else if (m_clr) m_ovf = 0;
        end
    end

    function automatic logic m_tx_exp();
        logic [9:0] frame;
        if (!m_in_frame) return 1'b1;
        frame = {1'b1, m_byte, 1'b0};
        return frame[m_pos / CPB];
    endfunction

    function automatic logic m_busy_exp();
        return m_in_frame || (m_q.size() != 0);
    endfunction

    // Per-cycle comparison of every output against the model, 1 ns after the edge.
    always @(posedge clk_100M) begin
        #1;
        if (model_on && rst_n) begin
            checkOutputBit("tx", tx, m_tx_exp());
            checkOutputBit("busy", busy, m_busy_exp());
            checkOutputBit("sel", sel, (mem_addr & 32'hFFFFFFF8) == BASE);
            checkOutput("rd_data", rd_data,
                        (((mem_addr & 32'hFFFFFFF8) == BASE) && mem_addr[2]) ?
                        {29'b0, m_ovf, m_q.size() == DEPTH, m_busy_exp()} : 32'b0);
        end
    end

    // Independent line decoder: samples each bit mid-period, counting enabled cycles only.
    logic [7:0] rx_q[$];
    bit         rx_active = 0;
    int         rx_cnt    = 0;
    logic [7:0] rx_byte   = 8'h00;

    always @(posedge clk_100M) begin
        #1;
        if (!rst_n) begin
            rx_active = 0;
        end else if (clk_en) begin
            if (!rx_active) begin
                if (tx == 1'b0) begin
                    rx_active = 1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2) begin
                    rx_byte[rx_cnt / CPB - 1] = tx;
                end else if (rx_cnt == 9 * CPB + CPB / 2) begin
                    checkOutputBit("rx_stop", tx, 1'b1);
                    rx_q.push_back(rx_byte);
                    rx_active = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic en);
        wr_en    = we;
        mem_addr = addr;
        w_data   = data;
        clk_en   = en;
        @(posedge clk_100M);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic readStatus(input string name, input logic [31:0] expected);
        wr_en    = 1'b0;
        mem_addr = STATUS;
        #1;
        checkOutput(name, rd_data, expected);
        checkOutputBit({name, "_sel"}, sel, 1'b1);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            idle(1);
            n++;
        end
        checkOutputBit({name, "_drain"}, busy, 1'b0);
    endtask

    // Expected bytes are packed with the first transmitted byte in the low 8 bits.
    task automatic checkRx(input string name, input logic [63:0] bytes, input int n);
        logic [7:0] e;
        checkOutput({name, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            e = bytes[8*i +: 8];
            checkOutput($sformatf("%s_byte%0d", name, i), {24'b0, rx_q[i]}, {24'b0, e});
        end
        rx_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by random traffic.
    initial begin
        logic [9:0]  pattern;
        logic [31:0] a;
        int          n, low, r;
        bit          ended;

        rst_n = 1'b0; clk_en = 1'b1; wr_en = 1'b0; mem_addr = 32'h0; w_data = 32'h0;
        repeat (3) @(posedge clk_100M);
        #2;
        rst_n = 1'b1;
        model_on = 1;
        checkOutputBit("reset_tx", tx, 1'b1);
        checkOutputBit("reset_busy", busy, 1'b0);
        readStatus("reset_status", 32'h0);

        // Single 0xA5 frame: start, 1,0,1,0,0,1,0,1, stop; four cycles each.
        applyStimulus(1'b1, TXDATA, 32'h000000A5, 1'b1);
        checkOutputBit("a5_pre_tx", tx, 1'b1);
        pattern = 10'b1101001010;
        for (int i = 0; i <= 40; i++) begin
            idle(1);
            if (i < 40) checkOutputBit($sformatf("a5_tx%0d", i), tx, pattern[i / CPB]);
            checkOutputBit($sformatf("a5_busy%0d", i), busy, i < 40);
        end
        checkRx("a5", 64'hA5, 1);

        // Back-to-back: three 40-cycle frames with two 1-cycle gaps after the first fall.
        applyStimulus(1'b1, TXDATA, 32'h41, 1'b1);
        applyStimulus(1'b1, TXDATA, 32'h42, 1'b1);
        applyStimulus(1'b1, TXDATA, 32'h43, 1'b1);
        n = 0;
        while (busy && n < 300) begin
            idle(1);
            n++;
        end
        checkOutput("b2b_cycles", 32'(n), 32'd121);
        readStatus("b2b_status", 32'h0);
        checkRx("b2b", 64'h434241, 3);

        // Overflow: 0x10 pops at once, 0x11..0x14 fill the FIFO, 0x15 is dropped.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, TXDATA, 32'(32'h10 + i), 1'b1);
        readStatus("ovf_status", 32'h7);
        applyStimulus(1'b1, STATUS, 32'h4, 1'b1);
        readStatus("ovf_cleared", 32'h3);
        drain("ovf", 400);
        readStatus("ovf_done", 32'h0);
        checkRx("ovf", 64'h1413121110, 5);

        // Full FIFO, push lands on the pop edge right after the first STOP completes.
        applyStimulus(1'b1, TXDATA, 32'h20, 1'b1);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, TXDATA, 32'(32'h20 + i), 1'b1);
        readStatus("full_status", 32'h3);
        idle(37);
        applyStimulus(1'b1, TXDATA, 32'h25, 1'b1);
        readStatus("pushpop_status", 32'h3);
        drain("pushpop", 400);
        checkRx("pushpop", 64'h252423222120, 6);

        // Reset while data bit 3 (a zero) of 0x30 is on the line, two bytes queued.
        applyStimulus(1'b1, TXDATA, 32'h30, 1'b1);
        applyStimulus(1'b1, TXDATA, 32'h31, 1'b1);
        applyStimulus(1'b1, TXDATA, 32'h32, 1'b1);
        idle(16);
        checkOutputBit("rst_pre_tx", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutputBit("rst_tx", tx, 1'b1);
        checkOutputBit("rst_busy", busy, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(100);
        checkOutputBit("rst_after_busy", busy, 1'b0);
        readStatus("rst_after_status", 32'h0);
        checkRx("rst", 64'h0, 0);

        // Decode: just past the window is ignored; the STATUS word is selected.
        applyStimulus(1'b1, 32'hFFFF0008, 32'h5A, 1'b1);
        checkOutputBit("dec_sel", sel, 1'b0);
        checkOutput("dec_rd", rd_data, 32'h0);
        idle(10);
        checkOutputBit("dec_busy", busy, 1'b0);
        readStatus("dec_status", 32'h0);

        // clk_en low for 10 cycles inside the start bit stretches it from 4 to 14.
        applyStimulus(1'b1, TXDATA, 32'h55, 1'b1);
        low = 0;
        ended = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, (c >= 2 && c < 12) ? 1'b0 : 1'b1);
            if (!ended) begin
                if (tx == 1'b0) low++;
                else if (low > 0) ended = 1;
            end
        end
        checkOutput("stretch_start_len", 32'(low), 32'd14);
        drain("stretch", 400);
        checkRx("stretch", 64'h55, 1);

        // Random traffic across the window, neighbours, and gated clock enables.
        m_sent.delete();
        rx_q.delete();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) a = TXDATA;
            else if (r < 8) a = STATUS;
            else if (r == 8) a = 32'hFFFF0008;
            else a = 32'h00001000;
            applyStimulus($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 4) != 0);
        end
        drain("rand", 600);
        checkOutput("rand_count", 32'(rx_q.size()), 32'(m_sent.size()));
        for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
            checkOutput($sformatf("rand_byte%0d", i), {24'b0, rx_q[i]}, {24'b0, m_sent[i]});

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
